// File: rtl/stripes_nbin_serializer_pkg.sv
// Shared definitions for the Stripes NBin bit-serial transmitter: default sizes,
// FSM state encoding and the precision clamp rule.
package stripes_nbin_serializer_pkg;

  localparam int N_DEF      = 16;
  localparam int TI_DEF     = 16;
  localparam int PREC_W_DEF = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // A zero or oversized precision means "send the full neuron width".
  function automatic int clamp_prec(input int p, input int n);
    return (p == 0 || p > n) ? n : p;
  endfunction

endpackage

// File: rtl/stripes_lead_one_detect.sv
// Finds the highest set bit position (+1) across all lanes of a block.
// An all-zero block reports 1 so that exactly one zero slice is still sent.
module stripes_lead_one_detect
  import stripes_nbin_serializer_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int Ti     = TI_DEF,
  parameter int PREC_W = PREC_W_DEF
) (
  input  logic [N*Ti-1:0]   blk_i,
  output logic [PREC_W-1:0] prec_o
);

  logic [Ti-1:0][N-1:0] lanes;
  logic [N-1:0]         any_bit;

  assign lanes = blk_i;

  always_comb begin
    any_bit = '0;
    for (int k = 0; k < Ti; k++) any_bit |= lanes[k];
  end

  always_comb begin
    prec_o = PREC_W'(1);
    for (int b = 0; b < N; b++)
      if (any_bit[b]) prec_o = PREC_W'(b + 1);
  end

endmodule

// File: rtl/stripes_nbin_serializer.sv
// Double-buffered MSB-first bit-serial transmitter for Stripes neuron blocks.
// Define STRIPES_DYN_PREC_EN to trim precision to the block's leading one.
module stripes_nbin_serializer
  import stripes_nbin_serializer_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int Ti     = TI_DEF,
  parameter int PREC_W = PREC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [N*Ti-1:0]   i_neurons,
  input  logic [PREC_W-1:0] i_precision,
  input  logic              i_stall,
  output logic              o_valid,
  output logic [Ti-1:0]     o_bits,
  output logic              o_first_cycle,
  output logic              o_last_cycle,
  output logic [PREC_W-1:0] o_precision
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [Ti-1:0][N-1:0] data;
    logic [PREC_W-1:0]    prec;
  } slot_t;

  logic [Ti-1:0][N-1:0] in_blk;
  logic [PREC_W-1:0]    prec_clamp;
  logic [PREC_W-1:0]    prec_eff;

  slot_t                shadow_q;
  logic                 shadow_full_q;
  logic [Ti-1:0][N-1:0] active_q;
  logic [PREC_W-1:0]    act_prec_q;
  logic [CNT_W-1:0]     cnt_q;
  state_e               state_q;

  logic                 valid_q;
  logic                 first_q;
  logic                 last_q;
  logic [Ti-1:0]        bits_q;
  logic [PREC_W-1:0]    prec_q;

  logic                 accept;
  logic                 reload;
  logic [CNT_W-1:0]     msb_idx;
  logic [Ti-1:0]        lane_bit;

  assign in_blk     = i_neurons;
  assign prec_clamp = PREC_W'(clamp_prec(int'(i_precision), N));

`ifdef STRIPES_DYN_PREC_EN
  logic [PREC_W-1:0] lead_prec;

  stripes_lead_one_detect #(
    .N      (N),
    .Ti     (Ti),
    .PREC_W (PREC_W)
  ) u_lod (
    .blk_i  (i_neurons),
    .prec_o (lead_prec)
  );

  assign prec_eff = (lead_prec < prec_clamp) ? lead_prec : prec_clamp;
`else
  assign prec_eff = prec_clamp;
`endif

  assign accept  = i_valid && !shadow_full_q;
  // Shadow moves to active from IDLE, or on the last bit of a block so blocks abut.
  assign reload  = !i_stall && shadow_full_q && (state_q == ST_IDLE || cnt_q == '0);
  assign msb_idx = CNT_W'(act_prec_q - PREC_W'(1));

  for (genvar k = 0; k < Ti; k++) begin : g_lane
    assign lane_bit[k] = active_q[k][cnt_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q.data <= in_blk;
        shadow_q.prec <= prec_eff;
      end
      shadow_full_q <= accept | (shadow_full_q & ~reload);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      act_prec_q <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      bits_q     <= '0;
      prec_q     <= '0;
    end else if (!i_stall) begin
      if (state_q == ST_SHIFT) begin
        valid_q <= 1'b1;
        bits_q  <= lane_bit;
        first_q <= (cnt_q == msb_idx);
        last_q  <= (cnt_q == '0);
        prec_q  <= act_prec_q;
      end else begin
        valid_q <= 1'b0;
        bits_q  <= '0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end

      if (reload) begin
        active_q   <= shadow_q.data;
        act_prec_q <= shadow_q.prec;
        cnt_q      <= CNT_W'(shadow_q.prec - PREC_W'(1));
        state_q    <= ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        if (cnt_q == '0) state_q <= ST_IDLE;
        else             cnt_q   <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign o_ready       = !shadow_full_q;
  assign o_valid       = valid_q;
  assign o_bits        = bits_q;
  assign o_first_cycle = first_q;
  assign o_last_cycle  = last_q;
  assign o_precision   = prec_q;

endmodule

// File: tb/tb_stripes_nbin_serializer.sv
// Directed + random bench for stripes_nbin_serializer against a slice-stream model.
module tb_stripes_nbin_serializer;

  localparam int N  = 16;
  localparam int TI = 16;
  localparam int PW = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [N*TI-1:0]   i_neurons = '0;
  logic [PW-1:0]     i_precision = '0;
  logic              i_stall = 1'b0;
  logic              o_valid;
  logic [TI-1:0]     o_bits;
  logic              o_first_cycle;
  logic              o_last_cycle;
  logic [PW-1:0]     o_precision;

  stripes_nbin_serializer #(.N(N), .Ti(TI), .PREC_W(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_neurons     (i_neurons),
    .i_precision   (i_precision),
    .i_stall       (i_stall),
    .o_valid       (o_valid),
    .o_bits        (o_bits),
    .o_first_cycle (o_first_cycle),
    .o_last_cycle  (o_last_cycle),
    .o_precision   (o_precision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TI-1:0] bits;
    bit            first;
    bit            last;
    int            prec;
  } slice_t;

  slice_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int n_slices, n_firsts, run, max_run, n_pushed;
  bit prev_con, accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bits actually sent for a block: clamp, then (optionally) trim to leading one.
  function automatic int eff_prec(input logic [N*TI-1:0] blk, input int p);
    int q;
    int top;
    q = (p == 0 || p > N) ? N : p;
    top = 0;
`ifdef STRIPES_DYN_PREC_EN
    for (int b = 0; b < N; b++)
      for (int k = 0; k < TI; k++)
        if (blk[k*N+b]) top = b + 1;
    if (top == 0) top = 1;
    if (top < q) q = top;
`endif
    return q;
  endfunction

  task automatic push_block(input logic [N*TI-1:0] blk, input int p);
    slice_t s;
    int q;
    q = eff_prec(blk, p);
    for (int b = q - 1; b >= 0; b--) begin
      for (int k = 0; k < TI; k++) s.bits[k] = blk[k*N+b];
      s.first = (b == q - 1);
      s.last  = (b == 0);
      s.prec  = q;
      exp_q.push_back(s);
      n_pushed++;
    end
  endtask

  task automatic reset_stats();
    n_slices = 0; n_firsts = 0; run = 0; max_run = 0; n_pushed = 0; prev_con = 0;
  endtask

  // One clock: check visible slice, record handshake, advance to #1 after next edge.
  task automatic step();
    slice_t s;
    if (o_valid) begin
      if (exp_q.size() == 0) chk("unexpected_slice", o_valid, 1'b0);
      else begin
        s = exp_q[0];
        chk("bits", o_bits, s.bits);
        chk("first", o_first_cycle, s.first);
        chk("last", o_last_cycle, s.last);
        chk("prec", o_precision, s.prec);
        if (!i_stall) begin
          void'(exp_q.pop_front());
          n_slices++;
          if (o_first_cycle) n_firsts++;
          run = prev_con ? run + 1 : 1;
          if (run > max_run) max_run = run;
          prev_con = 1;
        end
      end
    end else begin
      chk("idle_bits", o_bits, '0);
      prev_con = 0;
    end
    accepted = i_valid && o_ready;
    if (accepted) push_block(i_neurons, int'(i_precision));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [N*TI-1:0] blk, input int p);
    i_neurons = blk; i_precision = PW'(p); i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (accepted) break;
    end
    chk("send_accept", accepted, 1'b1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !o_valid) break;
      step();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [N*TI-1:0] rand_blk();
    logic [N*TI-1:0] b;
    for (int k = 0; k < TI; k++)
      b[k*N +: N] = N'($urandom_range(0, 65535) >> $urandom_range(0, 16));
    return b;
  endfunction

  initial begin
    logic [N*TI-1:0] blk;
    reset_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_bits", o_bits, '0);
    chk("rst_first", o_first_cycle, 1'b0);
    chk("rst_last", o_last_cycle, 1'b0);
    chk("rst_prec", o_precision, '0);
    reset = 1'b0;

    // 1: p=4, lane0=000B, latency two cycles after accept edge.
    reset_stats();
    blk = '0; blk[N-1:0] = 16'h000B;
    i_neurons = blk; i_precision = 5'd4; i_valid = 1'b1;
    step();
    chk("t1_accept", accepted, 1'b1);
    i_valid = 1'b0;
    chk("t1_lat0", o_valid, 1'b0);
    step();
    chk("t1_lat1", o_valid, 1'b0);
    step();
    chk("t1_first_valid", o_valid, 1'b1);
    chk("t1_first_flag", o_first_cycle, 1'b1);
    chk("t1_lane0_msb", o_bits[0], 1'b1);
    drain();
    chk("t1_slices", n_slices, 4);

    // 2: back-to-back p=3 blocks, no bubble.
    reset_stats();
    blk = rand_blk() & {TI{16'h0003}}; blk[2] = 1'b1;
    send(blk, 3);
    blk = rand_blk() & {TI{16'h0003}}; blk[N+2] = 1'b1;
    send(blk, 3);
    drain();
    chk("t2_run", max_run, 6);
    chk("t2_firsts", n_firsts, 2);

    // 3: p=0 and p=20 both clamp to full width.
    reset_stats();
    blk = rand_blk(); blk[N-1] = 1'b1;
    send(blk, 0);
    blk = rand_blk(); blk[2*N-1] = 1'b1;
    send(blk, 20);
    drain();
    chk("t3_slices", n_slices, 32);

    // 4: stall three cycles mid-block; shadow still accepts while stalled.
    reset_stats();
    blk = rand_blk() & {TI{16'h00FF}}; blk[7] = 1'b1;
    send(blk, 8);
    for (int i = 0; i < 20 && n_slices < 2; i++) step();
    chk("t4_reach", n_slices, 2);
    i_stall = 1'b1;
    blk = rand_blk() & {TI{16'h00FF}}; blk[N+7] = 1'b1;
    i_neurons = blk; i_precision = 5'd8; i_valid = 1'b1;
    step();
    chk("t4_stall_accept", accepted, 1'b1);
    i_valid = 1'b0;
    repeat (2) begin
      chk("t4_stall_valid", o_valid, 1'b1);
      step();
    end
    chk("t4_frozen", n_slices, 2);
    i_stall = 1'b0;
    drain();
    chk("t4_slices", n_slices, 16);

    // 5: reset at slice 2 of p=8 with a second block waiting.
    reset_stats();
    blk = rand_blk(); blk[7] = 1'b1;
    send(blk, 8);
    send(rand_blk(), 8);
    for (int i = 0; i < 20 && n_slices < 1; i++) step();
    chk("t5_reach", n_slices, 1);
    reset = 1'b1;
    #2;
    chk("t5_rst_valid", o_valid, 1'b0);
    chk("t5_rst_ready", o_ready, 1'b1);
    chk("t5_rst_bits", o_bits, '0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) step();
    chk("t5_no_stale", n_slices, 1);
    chk("t5_ready", o_ready, 1'b1);

    // Random traffic with stalls.
    reset_stats();
    for (int i = 0; i < 400; i++) begin
      i_neurons   = rand_blk();
      i_precision = PW'($urandom_range(0, 31));
      i_valid     = ($urandom_range(0, 2) != 0);
      i_stall     = ($urandom_range(0, 4) == 0);
      step();
    end
    i_stall = 1'b0;
    drain();
    chk("rand_count", n_slices, n_pushed);

    // 6: leading-one trimming (full width when the feature is off).
    reset_stats();
    blk = '0; blk[3*N +: N] = 16'h0005;
    send(blk, 16);
    send('0, 16);
    drain();
`ifdef STRIPES_DYN_PREC_EN
    chk("t6_slices", n_slices, 4);
`else
    chk("t6_slices", n_slices, 32);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
